// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared defaults and helpers for the N-channel router sync block
package router_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;
  localparam int CNT_W_DEF   = 5;
  localparam int MAX_CH      = 16;

  // One-hot decode of a channel number; out-of-range numbers decode to all zeros
  // so a rejected address can never select a FIFO.
  function automatic logic [MAX_CH-1:0] onehot(input logic [7:0] sel, input int n);
    logic [MAX_CH-1:0] v;
    v = '0;
    if (int'(sel) < n && int'(sel) < MAX_CH) begin
      v[sel[3:0]] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/router_wd_ctr.sv
// rtl/router_wd_ctr.sv - per-channel stall watchdog producing a one-cycle soft_reset pulse
// Ports:
//   clock, reset  : posedge clock, synchronous active-high reset
//   empty         : FIFO empty flag for this channel
//   read_enb      : downstream read strobe for this channel
//   wd_en         : watchdog enable; 0 holds the counter at zero
//   soft_reset    : one-cycle pulse after TIMEOUT consecutive unread-valid cycles
module router_wd_ctr #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic empty,
  input  logic read_enb,
  input  logic wd_en,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Activity (read/empty/disabled) takes priority over expiry, so a read on the
  // would-be expiry cycle suppresses the pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (empty || read_enb || !wd_en) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - address latch, write steering and stall watchdogs for an N-output router
// Ports:
//   clock, reset             : posedge clock, synchronous active-high reset
//   detect_add, data_in      : header address capture from the router FSM
//   write_enb_reg            : FSM request to write payload to the selected FIFO
//   wd_en, full, empty, read_enb : per-channel watchdog enables and FIFO status
//   write_enb                : one-hot FIFO write enable (combinational)
//   fifo_full                : full flag of the selected channel, 0 when address rejected
//   addr_err, addr_valid     : address range check results
//   soft_reset               : per-channel watchdog expiry pulses
//   vld_out                  : ~empty
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] wd_en,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_err,
  output logic              addr_valid,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] vld_out
);

  logic [ADDR_W-1:0] sel;
  logic [MAX_CH-1:0] sel_onehot;
  logic [NUM_CH-1:0] sel_mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      sel        <= '0;
      addr_valid <= 1'b1;
      addr_err   <= 1'b0;
    end else if (detect_add) begin
      sel        <= data_in;
      addr_valid <= (int'(data_in) < NUM_CH);
      addr_err   <= (int'(data_in) >= NUM_CH);
    end else begin
      addr_err   <= 1'b0;
    end
  end

  assign sel_onehot = onehot(8'(sel), NUM_CH);
  assign sel_mask   = sel_onehot[NUM_CH-1:0];

  // A rejected address drops the payload and reports not-full so the FSM drains it.
  assign write_enb = (write_enb_reg && addr_valid) ? sel_mask : '0;
  assign fifo_full = addr_valid && |(full & sel_mask);
  assign vld_out   = ~empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_wd
    router_wd_ctr #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
    ) u_wd (
      .clock     (clock),
      .reset     (reset),
      .empty     (empty[i]),
      .read_enb  (read_enb[i]),
      .wd_en     (wd_en[i]),
      .soft_reset(soft_reset[i])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// tb/tb_router_sync_n.sv - scoreboard bench for router_sync_n with directed and random stimulus
module tb_router_sync_n;

  localparam int NCH = 3;
  localparam int AW  = 2;
  localparam int TO  = 30;
  localparam int CW  = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           detect_add;
  logic           write_enb_reg;
  logic [AW-1:0]  data_in;
  logic [NCH-1:0] wd_en, full, empty, read_enb;
  logic [NCH-1:0] write_enb, soft_reset, vld_out;
  logic           fifo_full, addr_err, addr_valid;

  router_sync_n #(.NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
    .data_in(data_in), .wd_en(wd_en), .full(full), .empty(empty), .read_enb(read_enb),
    .write_enb(write_enb), .fifo_full(fifo_full), .addr_err(addr_err),
    .addr_valid(addr_valid), .soft_reset(soft_reset), .vld_out(vld_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NCH-1:0] we;
    logic           ff;
    logic           ae;
    logic           av;
    logic [NCH-1:0] sr;
    logic [NCH-1:0] vo;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: latched address, and per channel the length of the current
  // unbroken stall run; a pulse is due whenever that run is a multiple of TO.
  bit             m_known = 1'b0;
  int             m_sel;
  bit             m_valid, m_err;
  int             m_run[NCH];
  bit [NCH-1:0]   m_sr;

  function automatic exp_t expect_now();
    exp_t e;
    e.we = '0;
    if (write_enb_reg && m_valid && m_sel < NCH) e.we[m_sel] = 1'b1;
    e.ff = (m_valid && m_sel < NCH) ? full[m_sel] : 1'b0;
    e.ae = m_err;
    e.av = m_valid;
    e.sr = m_sr;
    e.vo = ~empty;
    return e;
  endfunction

  function automatic void model_update();
    if (reset) begin
      m_known = 1'b1;
      m_sel   = 0;
      m_valid = 1'b1;
      m_err   = 1'b0;
      m_sr    = '0;
      for (int i = 0; i < NCH; i++) m_run[i] = 0;
    end else if (m_known) begin
      if (detect_add) begin
        m_sel   = int'(data_in);
        m_valid = (m_sel < NCH);
        m_err   = (m_sel >= NCH);
      end else begin
        m_err   = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (empty[i] || read_enb[i] || !wd_en[i]) begin
          m_run[i] = 0;
          m_sr[i]  = 1'b0;
        end else begin
          m_run[i] = m_run[i] + 1;
          m_sr[i]  = (m_run[i] % TO == 0);
        end
      end
    end
  endfunction

  task automatic cycle();
    if (m_known) exp_q.push_back(expect_now());
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic drive(input bit rst, input bit det, input bit wer, input int din,
                       input logic [NCH-1:0] wd, input logic [NCH-1:0] fl,
                       input logic [NCH-1:0] em, input logic [NCH-1:0] rd);
    reset         = rst;
    detect_add    = det;
    write_enb_reg = wer;
    data_in       = AW'(din);
    wd_en         = wd;
    full          = fl;
    empty         = em;
    read_enb      = rd;
    cycle();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_enb",  8'(write_enb),  8'(e.we));
        check("fifo_full",  8'(fifo_full),  8'(e.ff));
        check("addr_err",   8'(addr_err),   8'(e.ae));
        check("addr_valid", 8'(addr_valid), 8'(e.av));
        check("soft_reset", 8'(soft_reset), 8'(e.sr));
        check("vld_out",    8'(vld_out),    8'(e.vo));
      end
    end
  end

  initial begin : stimulus
    drive(1, 0, 0, 0, 3'b111, 3'b000, 3'b111, 3'b000);
    drive(1, 0, 0, 0, 3'b111, 3'b000, 3'b111, 3'b000);
    drive(0, 0, 0, 0, 3'b111, 3'b000, 3'b111, 3'b000);

    // Steering to channel 2, full flag follows full[2].
    drive(0, 1, 0, 2, 3'b111, 3'b000, 3'b111, 3'b000);
    for (int k = 0; k < 4; k++)
      drive(0, 0, 1, 0, 3'b111, NCH'($urandom_range(0, 7)), 3'b111, 3'b000);

    // Out-of-range address: error pulse, no writes, fifo_full masked.
    drive(0, 1, 0, 3, 3'b111, 3'b111, 3'b111, 3'b000);
    for (int k = 0; k < 3; k++)
      drive(0, 0, 1, 0, 3'b111, 3'b111, 3'b111, 3'b000);

    // Channel 0 stalled: pulses at 30 and 60.
    drive(0, 1, 0, 0, 3'b111, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 65; k++)
      drive(0, 0, 0, 0, 3'b111, 3'b000, 3'b110, 3'b000);

    // Read on cycle 29 suppresses the first pulse.
    drive(0, 0, 0, 0, 3'b111, 3'b000, 3'b111, 3'b000);
    for (int k = 1; k <= 70; k++)
      drive(0, 0, 0, 0, 3'b111, 3'b000, 3'b110, (k == 29) ? 3'b001 : 3'b000);

    // Watchdog disabled on channel 1 while channels 1 and 2 stall.
    for (int k = 0; k < 40; k++)
      drive(0, 0, 0, 0, 3'b101, 3'b000, 3'b001, 3'b000);

    // Reset mid-packet with sel=1.
    drive(0, 1, 0, 1, 3'b111, 3'b000, 3'b111, 3'b000);
    drive(0, 0, 1, 0, 3'b111, 3'b000, 3'b111, 3'b000);
    drive(1, 0, 1, 0, 3'b111, 3'b000, 3'b101, 3'b000);
    drive(0, 0, 1, 0, 3'b111, 3'b000, 3'b111, 3'b000);

    // Random traffic with rare reads, rare emptiness and occasional resets.
    begin
      logic [NCH-1:0] wd, em, rd;
      wd = 3'b111;
      for (int k = 0; k < 3000; k++) begin
        if (k % 200 == 0) wd = NCH'($urandom_range(0, 7));
        for (int i = 0; i < NCH; i++) begin
          em[i] = ($urandom_range(0, 99) < 2);
          rd[i] = ($urandom_range(0, 99) < 2);
        end
        drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0),
              $urandom_range(0, 1), $urandom_range(0, 3), wd,
              NCH'($urandom_range(0, 7)), em, rd);
      end
    end

    drive(0, 0, 0, 0, 3'b111, 3'b000, 3'b111, 3'b000);
    repeat (3) @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
